ysyx_axi4_sram_slave: RTL and testbench
=======================================

# ysyx_axi4_sram_slave

AXI4 responder that terminates the core's master port in simulation-only and FPGA builds: accepts read and write bursts from the bus arbiter and serves them from an internal 64-bit-wide memory array. Read and write channels run independent state machines, with one outstanding transaction per direction. A programmable read latency exercises the arbiter's wait paths.

## Interface
- `ADDR_W`, 32: address width.
- `DEPTH`, 4096: memory size in 64-bit words.
- `BASE`, 32'h8000_0000: first byte address served.
- `RD_LAT`, 2: cycles from AR handshake to first `rvalid`, minimum 1.
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`  in  4/ADDR_W/8/3/2: read request.
- `arvalid` in 1; `arready` out 1.
- `rid` out 4; `rdata` out 64; `rresp` out 2; `rlast` out 1; `rvalid` out 1; `rready` in 1.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`  in  4/ADDR_W/8/3/2: write request.
- `awvalid` in 1; `awready` out 1.
- `wdata` in 64; `wstrb` in 8; `wlast` in 1; `wvalid` in 1; `wready` out 1.
- `bid` out 4; `bresp` out 2; `bvalid` out 1; `bready` in 1.

## Operation
- Read FSM states:
  - R_IDLE, `arready`=1. On AR handshake: latch id, addr, len, size, burst; load the latency counter with RD_LAT-1; go to R_WAIT.
  - R_WAIT: the counter decrements; at 0, go to R_DATA.
  - R_DATA: `rvalid`=1. `rdata` = mem[index(addr)], full 64-bit word; the master selects lanes. `rlast`=1 when beat count == len. Each `rvalid&rready` advances addr and beat. The last beat accepted returns the FSM to R_IDLE.
- Write FSM states:
  - W_IDLE, `awready`=1. On AW handshake: latch request; go to W_DATA.
  - W_DATA: `wready`=1. Each `wvalid&wready` writes bytes of `wdata` where `wstrb[i]`=1. The beat with count == len ends the burst; go to W_RESP.
  - W_RESP: `bvalid`=1 until `bready`; then go to W_IDLE.
  - The W channel is not accepted before AW; W beats arriving early stall on `wready`=0.
- Address update per beat:
  - FIXED (00): address unchanged.
  - INCR (01): addr += 1<<size.
  - WRAP (10) and reserved (11): every beat answers SLVERR; there is no memory access and no write.
  - index(addr) = (addr-BASE)>>3, computed ADDR_W wide. Address wrap-around at 2^ADDR_W is not special-cased.
- Error rules:
  - A beat is out of range if addr < BASE or addr ≥ BASE+DEPTH*8. Out-of-range read beat: `rresp`=2'b10 (SLVERR), `rdata`=0. Out-of-range write beat: dropped.
  - `bresp` = SLVERR if any beat of the burst errored, or if `wlast` disagrees with the beat count on any beat. Otherwise OKAY.
  - `rid`/`bid` echo the latched ids.
- Simultaneous read and write to the same word in one cycle: read returns the old data; the write commits at the clock edge.
- Reset: both FSMs go to idle; counters clear; memory contents are kept. Reset mid-burst abandons the burst without a response.

## Timing
- Reset values: `arready`=1, `awready`=1, `rvalid`=0, `wready`=0, `bvalid`=0, `rlast`=0, `rresp`=0, `bresp`=0, `rdata`=0, `rid`=0, `bid`=0.
- All outputs are registered or decoded from FSM state. No combinational path runs from any valid/ready input to any output.
- Read latency: AR handshake at edge N gives `rvalid`=1 in cycle N+RD_LAT. With `rready` held at 1, the burst streams one beat per cycle.
- Write: AW at edge N gives `wready`=1 in cycle N+1. Final W beat at edge M gives `bvalid`=1 in cycle M+1.
- `rvalid`, `rdata`, `rlast`, `rresp` hold stable while `rready`=0. `bvalid`/`bresp` hold stable likewise.
- Ready deasserts in the cycle after a handshake, so back-to-back transactions need at least one idle cycle per direction.

## Structure
- Shared package `ysyx_axi_pkg`:
  - response codes OKAY=2'b00, SLVERR=2'b10;
  - burst encodings FIXED/INCR/WRAP;
  - FSM state enums.
- Natural sub-module: `ysyx_axi4_sram_mem`, the byte-enabled 64-bit dual-port array. It has one combinational read port and one write port with `wstrb` enables.

## Test plan
- Single read: preload mem[0]=64'h1122334455667788; AR addr 0x8000_0000, len 0, size 3. Expect `rvalid` at cycle +2, `rdata`=64'h1122334455667788, `rlast`=1, `rresp`=0.
- INCR write burst: AW addr 0x8000_0010, len 3, size 3; four beats, `wstrb`=8'hFF, data 1..4. Expect `bresp`=0. Then read back the same burst: data 1,2,3,4 with `rlast` only on beat 4.
- Partial strobe: mem[1]=0; write 64'hAABBCCDD_EEFF0011 with `wstrb`=8'h0F. Read of mem[1] returns 64'h00000000_EEFF0011.
- Back-pressure: hold `rready`=0 for 5 cycles mid-burst. `rdata`/`rlast` stay stable; no beat is lost or duplicated.
- Errors:
  - AR addr 0x7FFF_FFF8 gives SLVERR and `rdata`=0.
  - AW with `awburst`=2'b10, len 1, gives `bresp`=SLVERR and memory unchanged.
  - `wlast`=1 on beat 0 of a len-1 burst gives SLVERR.
- Reset mid-read: assert `rst` during R_DATA. Next cycle `rvalid`=0 and `arready`=1, and memory contents are preserved.

Source files
------------

// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4 encodings and FSM state codes for the SRAM responder.
package ysyx_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef logic [1:0] rd_state_t;
    typedef logic [1:0] wr_state_t;

    localparam rd_state_t R_IDLE = 2'd0;
    localparam rd_state_t R_WAIT = 2'd1;
    localparam rd_state_t R_DATA = 2'd2;

    localparam wr_state_t W_IDLE = 2'd0;
    localparam wr_state_t W_DATA = 2'd1;
    localparam wr_state_t W_RESP = 2'd2;

    // Only FIXED and INCR touch memory; WRAP and reserved always error.
    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/ysyx_axi4_sram_mem.sv
// Byte-enabled 64-bit array: one combinational read port, one write port.
module ysyx_axi4_sram_mem #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] raddr,
    output logic [63:0]      rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [63:0]      wdata,
    input  logic [7:0]       wstrb
);

    logic [63:0] mem_q [DEPTH];

    assign rdata = mem_q[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) begin
                    mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 SRAM responder with independent read/write FSMs and
// a programmable read latency.
module ysyx_axi4_sram_slave
    import ysyx_axi_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE   = 'h8000_0000,
    parameter int                RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   LO       = {1'b0, BASE};
    localparam logic [ADDR_W:0]   HI       = LO + (ADDR_W+1)'(DEPTH * 8);
    localparam logic [7:0]        LAT_INIT = 8'(RD_LAT - 1);

    function automatic logic beat_err(input logic [ADDR_W-1:0] a,
                                      input logic [1:0] burst);
        logic [ADDR_W:0] ax;
        ax = {1'b0, a};
        return !burst_ok(burst) || (ax < LO) || (ax >= HI);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] n;
        case (burst)
            BURST_INCR:              n = a + (ADDR_W'(1) << size);
            BURST_FIXED, BURST_WRAP: n = a;
            default:                 n = a;
        endcase
        return n;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    // ---------------- read channel ----------------
    rd_state_t         r_state_q, r_state_d;
    logic [3:0]        rid_q, rid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d;
    logic [7:0]        rbeat_q, rbeat_d;
    logic [7:0]        rcnt_q, rcnt_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;

    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_burst;
    logic [7:0]        ld_beat;
    logic [7:0]        ld_len;
    logic              ld_err;
    logic [ADDR_W-1:0] r_nxt;
    logic [63:0]       mem_rdata;

    assign r_nxt  = next_addr(raddr_q, rsize_q, rburst_q);
    assign ld_err = beat_err(ld_addr, ld_burst);

    // The next beat is fetched into rdata_q ahead of time so the R
    // outputs stay registered and stable under back-pressure.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        rcnt_d    = rcnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        ld_en     = 1'b0;
        ld_addr   = raddr_q;
        ld_burst  = rburst_q;
        ld_beat   = rbeat_q;
        ld_len    = rlen_q;
        case (r_state_q)
            R_IDLE: begin
                ld_addr  = araddr;
                ld_burst = arburst;
                ld_beat  = 8'd0;
                ld_len   = arlen;
                if (arvalid) begin
                    rid_d    = arid;
                    raddr_d  = araddr;
                    rlen_d   = arlen;
                    rsize_d  = arsize;
                    rburst_d = arburst;
                    rbeat_d  = 8'd0;
                    if (LAT_INIT == 8'd0) begin
                        r_state_d = R_DATA;
                        ld_en     = 1'b1;
                    end else begin
                        r_state_d = R_WAIT;
                        rcnt_d    = LAT_INIT;
                    end
                end
            end
            R_WAIT: begin
                rcnt_d = rcnt_q - 8'd1;
                if (rcnt_q == 8'd1) begin
                    r_state_d = R_DATA;
                    ld_en     = 1'b1;
                end
            end
            R_DATA: begin
                ld_addr = r_nxt;
                ld_beat = rbeat_q + 8'd1;
                if (rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = r_nxt;
                        rbeat_d = rbeat_q + 8'd1;
                        ld_en   = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (ld_en) begin
            rdata_d = ld_err ? 64'd0 : mem_rdata;
            rresp_d = ld_err ? RESP_SLVERR : RESP_OKAY;
            rlast_d = (ld_beat == ld_len);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rid_q     <= 4'd0;
            raddr_q   <= '0;
            rlen_q    <= 8'd0;
            rsize_q   <= 3'd0;
            rburst_q  <= 2'd0;
            rbeat_q   <= 8'd0;
            rcnt_q    <= 8'd0;
            rdata_q   <= 64'd0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            rcnt_q    <= rcnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

    // ---------------- write channel ----------------
    wr_state_t         w_state_q, w_state_d;
    logic [3:0]        bid_q, bid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d;
    logic [7:0]        wbeat_q, wbeat_d;
    logic              werr_q, werr_d;
    logic [1:0]        bresp_q, bresp_d;

    logic w_beat_err;
    logic w_is_last;
    logic w_err_acc;
    logic mem_we;

    assign w_beat_err = beat_err(waddr_q, wburst_q);
    assign w_is_last  = (wbeat_q == wlen_q);
    assign w_err_acc  = werr_q | w_beat_err | (wlast != w_is_last);

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    bid_d     = awid;
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wsize_d   = awsize;
                    wburst_d  = awburst;
                    wbeat_d   = 8'd0;
                    werr_d    = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_we = !w_beat_err;
                    if (w_is_last) begin
                        bresp_d   = w_err_acc ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        werr_d  = w_err_acc;
                        waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
                        wbeat_d = wbeat_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            bid_q     <= 4'd0;
            waddr_q   <= '0;
            wlen_q    <= 8'd0;
            wsize_q   <= 3'd0;
            wburst_q  <= 2'd0;
            wbeat_q   <= 8'd0;
            werr_q    <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = bid_q;
    assign bresp   = bresp_q;

    ysyx_axi4_sram_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .raddr (word_idx(ld_addr)),
        .rdata (mem_rdata),
        .we    (mem_we),
        .waddr (word_idx(waddr_q)),
        .wdata (wdata),
        .wstrb (wstrb)
    );

endmodule

// File: tb/tb_ysyx_axi4_sram_slave.sv
// Bench for ysyx_axi4_sram_slave: vector table plus a read scoreboard
// backed by a shadow memory model.
module tb_ysyx_axi4_sram_slave;
    import ysyx_axi_pkg::*;

    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          RD_LAT = 2;
    localparam logic [32:0] LIM    = 33'(BASE) + 33'(DEPTH * 8);

    logic        clk, rst;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [63:0] rdata, wdata;

    ysyx_axi4_sram_slave #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BASE   (BASE),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [63:0] shadow [int];

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;
    rexp_t rq[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [63:0] d0;
        logic        bad_wl;
        logic [1:0]  exp_bresp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_map(input logic [31:0] a, input logic [1:0] b);
        return (b == BURST_FIXED || b == BURST_INCR) &&
               ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIM);
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] b);
        return (b == BURST_INCR) ? a + 32'd8 : a;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [7:0] strb, input logic [63:0] d0,
                             input logic bad_wl, output logic [1:0] resp);
        logic [31:0] a;
        logic [63:0] old;
        logic        hs;
        int          n;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd3;
        awburst = burst; awvalid = 1'b1;
        wdata = d0; wstrb = strb; wlast = (len == 8'd0) || bad_wl; wvalid = 1'b1;
        chk("wready_before_aw", wready, 0);
        hs = 1'b0; n = 0;
        while (!hs && n < 50) begin hs = awready; tick(); n++; end
        awvalid = 1'b0;
        chk("aw_handshake", hs, 1);
        chk("wready_after_aw", wready, 1);
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            wdata = d0 + 64'(k);
            wstrb = strb;
            wlast = (k == int'(len)) || (bad_wl && k == 0);
            wvalid = 1'b1;
            hs = 1'b0; n = 0;
            while (!hs && n < 50) begin hs = wready; tick(); n++; end
            if (!hs) begin
                chk("w_handshake", hs, 1);
                break;
            end
            if (in_map(a, burst)) begin
                old = shadow.exists(widx(a)) ? shadow[widx(a)] : 64'd0;
                for (int b = 0; b < 8; b++)
                    if (strb[b]) old[b*8 +: 8] = wdata[b*8 +: 8];
                shadow[widx(a)] = old;
            end
            a = nxt(a, burst);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_latency", bvalid, 1);
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        resp = bresp;
        chk("bid", bid, 64'(id));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 0);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input int stall_beat);
        logic [31:0] a;
        logic [63:0] hd;
        logic [1:0]  hr;
        logic        hl, hs;
        rexp_t       e;
        int          n, lat, beat;
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            e.last = (k == int'(len));
            if (in_map(a, burst)) begin
                e.data = shadow.exists(widx(a)) ? shadow[widx(a)] : 64'd0;
                e.resp = RESP_OKAY;
            end else begin
                e.data = 64'd0;
                e.resp = RESP_SLVERR;
            end
            rq.push_back(e);
            a = nxt(a, burst);
        end
        arid = id; araddr = addr; arlen = len; arsize = 3'd3;
        arburst = burst; arvalid = 1'b1; rready = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 50) begin hs = arready; tick(); n++; end
        arvalid = 1'b0;
        chk("ar_handshake", hs, 1);
        lat = 1;
        while (!rvalid && lat < 50) begin tick(); lat++; end
        chk("rd_latency", 64'(lat), 64'(RD_LAT));
        beat = 0;
        while (1) begin
            n = 0;
            while (!rvalid && n < 50) begin tick(); n++; end
            if (!rvalid) begin
                chk("rvalid_timeout", rvalid, 1);
                break;
            end
            if (beat > 0) chk("stream_gap", 64'(n), 0);
            if (rq.size() == 0) begin
                chk("extra_beat", 1, 0);
                break;
            end
            e = rq.pop_front();
            if (beat == stall_beat) begin
                rready = 1'b0;
                hd = rdata; hl = rlast; hr = rresp;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_rvalid", rvalid, 1);
                    chk("stall_rdata", rdata, hd);
                    chk("stall_rlast", rlast, 64'(hl));
                    chk("stall_rresp", rresp, 64'(hr));
                end
                rready = 1'b1;
            end
            chk("rdata", rdata, e.data);
            chk("rresp", rresp, 64'(e.resp));
            chk("rlast", rlast, 64'(e.last));
            chk("rid", rid, 64'(id));
            hl = rlast;
            tick();
            beat++;
            if (hl || beat > int'(len)) break;
        end
        rready = 1'b0;
        chk("scoreboard_empty", 64'(rq.size()), 0);
        rq.delete();
        chk("arready_after_burst", arready, 1);
    endtask

    vec_t        vt [17];
    logic [1:0]  r;
    int          n;
    logic        hs;

    initial begin
        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        wvalid = 1'b0; bready = 1'b0;

        vt[0]  = '{1'b1, 32'h8000_0000, 8'd0, BURST_INCR,  8'hFF, 64'h1122334455667788, 1'b0, RESP_OKAY};
        vt[1]  = '{1'b0, 32'h8000_0000, 8'd0, BURST_INCR,  8'h00, 64'd0, 1'b0, RESP_OKAY};
        vt[2]  = '{1'b1, 32'h8000_0010, 8'd3, BURST_INCR,  8'hFF, 64'd1, 1'b0, RESP_OKAY};
        vt[3]  = '{1'b0, 32'h8000_0010, 8'd3, BURST_INCR,  8'h00, 64'd0, 1'b0, RESP_OKAY};
        vt[4]  = '{1'b1, 32'h8000_0008, 8'd0, BURST_INCR,  8'hFF, 64'd0, 1'b0, RESP_OKAY};
        vt[5]  = '{1'b1, 32'h8000_0008, 8'd0, BURST_INCR,  8'h0F, 64'hAABBCCDDEEFF0011, 1'b0, RESP_OKAY};
        vt[6]  = '{1'b0, 32'h8000_0008, 8'd0, BURST_INCR,  8'h00, 64'd0, 1'b0, RESP_OKAY};
        vt[7]  = '{1'b0, 32'h7FFF_FFF8, 8'd0, BURST_INCR,  8'h00, 64'd0, 1'b0, RESP_OKAY};
        vt[8]  = '{1'b1, 32'h8000_0010, 8'd1, BURST_WRAP,  8'hFF, 64'hDEAD, 1'b0, RESP_SLVERR};
        vt[9]  = '{1'b0, 32'h8000_0010, 8'd1, BURST_INCR,  8'h00, 64'd0, 1'b0, RESP_OKAY};
        vt[10] = '{1'b1, 32'h8000_0100, 8'd2, BURST_FIXED, 8'hFF, 64'h10, 1'b0, RESP_OKAY};
        vt[11] = '{1'b0, 32'h8000_0100, 8'd1, BURST_FIXED, 8'h00, 64'd0, 1'b0, RESP_OKAY};
        vt[12] = '{1'b1, 32'h8000_7FF8, 8'd1, BURST_INCR,  8'hFF, 64'hCAFE0, 1'b0, RESP_SLVERR};
        vt[13] = '{1'b0, 32'h8000_7FF8, 8'd1, BURST_INCR,  8'h00, 64'd0, 1'b0, RESP_OKAY};
        vt[14] = '{1'b1, 32'h8000_8000, 8'd0, BURST_INCR,  8'hFF, 64'd5, 1'b0, RESP_SLVERR};
        vt[15] = '{1'b0, 32'h8000_0000, 8'd0, BURST_WRAP,  8'h00, 64'd0, 1'b0, RESP_OKAY};
        vt[16] = '{1'b1, 32'h8000_0200, 8'd1, BURST_INCR,  8'hFF, 64'h77, 1'b1, RESP_SLVERR};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_arready", arready, 1);
        chk("reset_awready", awready, 1);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_wready", wready, 0);
        chk("reset_bvalid", bvalid, 0);
        chk("reset_rlast", rlast, 0);
        chk("reset_rresp", rresp, 0);
        chk("reset_bresp", bresp, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_rid", rid, 0);
        chk("reset_bid", bid, 0);

        for (int i = 0; i < 17; i++) begin
            if (vt[i].wr) begin
                axi_write(4'(i), vt[i].addr, vt[i].len, vt[i].burst,
                          vt[i].strb, vt[i].d0, vt[i].bad_wl, r);
                chk($sformatf("bresp_vec%0d", i), 64'(r), 64'(vt[i].exp_bresp));
            end else begin
                axi_read(4'(i), vt[i].addr, vt[i].len, vt[i].burst, -1);
            end
            tick();
        end

        // back-pressure in the middle of a burst
        axi_read(4'hA, 32'h8000_0010, 8'd3, BURST_INCR, 1);
        tick();

        // reset while a read burst is presenting data
        arid = 4'h5; araddr = 32'h8000_0010; arlen = 8'd3; arsize = 3'd3;
        arburst = BURST_INCR; arvalid = 1'b1; rready = 1'b0;
        hs = 1'b0; n = 0;
        while (!hs && n < 50) begin hs = arready; tick(); n++; end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        chk("pre_reset_rvalid", rvalid, 1);
        rst = 1'b1;
        tick();
        chk("mid_reset_rvalid", rvalid, 0);
        chk("mid_reset_arready", arready, 1);
        rst = 1'b0;
        tick();
        axi_read(4'h6, 32'h8000_0010, 8'd3, BURST_INCR, -1);
        axi_read(4'h7, 32'h8000_0000, 8'd1, BURST_INCR, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
